// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one single-port memory bus between instruction fetch (IF) and data
//   access (MEM), and builds the 6-bit pipeline stall vector from the pending bus
//   requests plus the ID/EX stall requests (deepest requester wins).
//   Stall bit order: [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB.
//
// Parameters
//   WAIT_MAX     bus cycles without bus_ack before a transaction is aborted (0 = never)
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   if_req, if_addr           fetch request and address
//   mem_req, mem_we, mem_addr, mem_wdata, mem_sel
//                             data access request (1=write), address, data, byte enables
//   stallreq_id, stallreq_ex  stall requests from ID (load-use) and EX (multi-cycle)
//   bus_req, bus_we, bus_addr, bus_wdata, bus_sel
//                             registered bus transaction, held stable until bus_ack
//   bus_ack, bus_rdata        one-cycle completion pulse and read data
//   if_inst, mem_rdata        last fetched instruction / last read data (held)
//   bus_err                   one-cycle pulse on timeout abort
//   stall                     pipeline stall vector

module mem_bus_arbiter #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] mem_rdata,
    output logic        bus_err,
    output logic [5:0]  stall
);

    // Counter only has to reach WAIT_MAX-1: the abort happens on the cycle that
    // would have been the WAIT_MAX-th one without an ack.
    localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);
    localparam bit TimeoutEn = (WAIT_MAX != 0);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StFetch
    } state_e;

    state_e state_q, state_d;

    logic            if_done_q, if_done_d;
    logic            mem_done_q, mem_done_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [31:0]     bus_addr_q, bus_addr_d;
    logic [31:0]     bus_wdata_q, bus_wdata_d;
    logic [3:0]      bus_sel_q, bus_sel_d;
    logic [31:0]     if_inst_q, if_inst_d;
    logic [31:0]     mem_rdata_q, mem_rdata_d;
    logic            bus_err_q, bus_err_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    logic            if_pend;
    logic            mem_pend;
    logic [5:0]      stall_int;

    // Pending requests and stall vector
    always_comb begin
        if_pend  = if_req & ~if_done_q;
        mem_pend = mem_req & ~mem_done_q;

        if (mem_pend) begin
            stall_int = 6'b011111;
        end else if (stallreq_ex) begin
            stall_int = 6'b001111;
        end else if (stallreq_id) begin
            stall_int = 6'b000111;
        end else if (if_pend) begin
            stall_int = 6'b000011;
        end else begin
            stall_int = 6'b000000;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        if_done_d   = if_done_q;
        mem_done_d  = mem_done_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = 1'b0;
        wait_cnt_d  = wait_cnt_q;

        // A done flag lives until its stage accepts the next instruction.
        if (!stall_int[4]) begin
            mem_done_d = 1'b0;
        end
        if (!stall_int[1]) begin
            if_done_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // A late ack arriving here is deliberately ignored.
                if (mem_pend) begin
                    state_d     = StData;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_sel_d   = mem_sel;
                    wait_cnt_d  = '0;
                end else if (if_pend) begin
                    state_d     = StFetch;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    bus_sel_d   = 4'hF;
                    wait_cnt_d  = '0;
                end
            end

            StData: begin
                if (bus_ack) begin
                    // Completed even if mem_req dropped (flush); only then skip done.
                    if (!bus_we_q) begin
                        mem_rdata_d = bus_rdata;
                    end
                    if (mem_req) begin
                        mem_done_d = 1'b1;
                    end
                    bus_req_d  = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = StIdle;
                end else if (TimeoutEn && (wait_cnt_q == CntLast)) begin
                    if (!bus_we_q) begin
                        mem_rdata_d = '0;
                    end
                    mem_done_d = 1'b1;
                    bus_err_d  = 1'b1;
                    bus_req_d  = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = StIdle;
                end else if (TimeoutEn) begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end

            StFetch: begin
                if (bus_ack) begin
                    if_inst_d = bus_rdata;
                    if (if_req) begin
                        if_done_d = 1'b1;
                    end
                    bus_req_d  = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = StIdle;
                end else if (TimeoutEn && (wait_cnt_q == CntLast)) begin
                    if_inst_d  = '0;
                    if_done_d  = 1'b1;
                    bus_err_d  = 1'b1;
                    bus_req_d  = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = StIdle;
                end else if (TimeoutEn) begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end

            default: begin
                state_d   = StIdle;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
            bus_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_sel   = bus_sel_q;
    assign if_inst   = if_inst_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_err   = bus_err_q;

    // Stall released the moment reset is asserted, even with requests still high.
    assign stall = rst ? stall_int : 6'b000000;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter. A responder models the memory bus, a monitor checks
// every completed / aborted bus transaction against an expected-transaction queue,
// and the directed stimulus thread checks stall vector and captured data.

module tb_mem_bus_arbiter;

    localparam int unsigned WaitMax = 4;

    typedef struct packed {
        logic        kind;   // 0 = acked, 1 = timeout abort
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [31:0] if_inst;
    logic [31:0] mem_rdata;
    logic        bus_err;
    logic [5:0]  stall;

    int          checks = 0;
    int          errors = 0;
    int          ack_wait = 0;     // wait cycles before ack; -1 = never ack
    bit          stray_ack = 1'b0; // pulse ack while the bus is idle
    txn_t        exp_q[$];
    logic [31:0] rsp_q[$];

    mem_bus_arbiter #(.WAIT_MAX(WaitMax)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_sel     (mem_sel),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_sel     (bus_sel),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .if_inst     (if_inst),
        .mem_rdata   (mem_rdata),
        .bus_err     (bus_err),
        .stall       (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_txn(input logic kind, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] sel);
        txn_t t;
        t.kind  = kind;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        t.sel   = sel;
        exp_q.push_back(t);
    endtask

    // One clock; a request whose stall bit was clear at the edge is consumed,
    // as the pipeline would advance past it.
    task automatic step();
        logic [5:0] s;
        s = stall;
        @(posedge clk);
        #1;
        if (mem_req && !s[4]) mem_req = 1'b0;
        if (if_req && !s[1]) if_req = 1'b0;
        #1;
    endtask

    // Bus responder: drives ack on the falling edge
    initial begin
        int wcnt;
        wcnt      = 0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (rst && bus_req) begin
                if (ack_wait >= 0 && wcnt == ack_wait) begin
                    bus_ack   = 1'b1;
                    bus_rdata = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'h0;
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                if (stray_ack) begin
                    bus_ack   = 1'b1;
                    bus_rdata = 32'hFFFF_FFFF;
                end
            end
        end
    end

    // Monitor: field stability while pending, scoreboard pop on ack / abort
    initial begin
        logic        in_txn;
        logic        t_we;
        logic [31:0] t_addr;
        logic [31:0] t_wdata;
        logic [3:0]  t_sel;
        txn_t        e;
        in_txn = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                in_txn = 1'b0;
            end else begin
                if (bus_req) begin
                    if (!in_txn) begin
                        in_txn  = 1'b1;
                        t_we    = bus_we;
                        t_addr  = bus_addr;
                        t_wdata = bus_wdata;
                        t_sel   = bus_sel;
                    end else begin
                        chk("stable bus_addr", bus_addr, t_addr);
                        chk("stable bus_we/sel/wdata", {bus_we, bus_sel, bus_wdata[26:0]},
                            {t_we, t_sel, t_wdata[26:0]});
                    end
                    if (bus_ack) begin
                        in_txn = 1'b0;
                        if (exp_q.size() == 0) begin
                            chk("unexpected ack txn addr", bus_addr, 32'hXXXX_XXXX);
                        end else begin
                            e = exp_q.pop_front();
                            chk("txn kind", 32'd0, {31'd0, e.kind});
                            chk("txn we", {31'd0, bus_we}, {31'd0, e.we});
                            chk("txn addr", bus_addr, e.addr);
                            chk("txn wdata", bus_wdata, e.wdata);
                            chk("txn sel", {28'd0, bus_sel}, {28'd0, e.sel});
                        end
                    end
                end
                if (bus_err) begin
                    in_txn = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected bus_err addr", t_addr, 32'hXXXX_XXXX);
                    end else begin
                        e = exp_q.pop_front();
                        chk("abort kind", 32'd1, {31'd0, e.kind});
                        chk("abort addr", t_addr, e.addr);
                        chk("abort we", {31'd0, t_we}, {31'd0, e.we});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        rst = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        mem_sel = '0;
        stallreq_id = 1'b0;
        stallreq_ex = 1'b0;

        // Reset state
        @(posedge clk);
        #2;
        chk("reset bus_req", {31'd0, bus_req}, 32'd0);
        chk("reset stall", {26'd0, stall}, 32'd0);
        chk("reset if_inst", if_inst, 32'd0);
        chk("reset mem_rdata", mem_rdata, 32'd0);
        chk("reset bus_err", {31'd0, bus_err}, 32'd0);
        chk("reset bus_addr", bus_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        step();

        // 1: zero-wait fetch
        ack_wait = 0;
        rsp_q.push_back(32'h3C01_0001);
        push_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
        if_req = 1'b1;
        if_addr = 32'h100;
        #1;
        chk("t1 stall c0", {26'd0, stall}, 32'h03);
        step();
        chk("t1 stall c1", {26'd0, stall}, 32'h03);
        chk("t1 bus_req c1", {31'd0, bus_req}, 32'd1);
        step();
        chk("t1 stall done", {26'd0, stall}, 32'h00);
        chk("t1 if_inst", if_inst, 32'h3C01_0001);
        chk("t1 bus_req done", {31'd0, bus_req}, 32'd0);
        step();
        chk("t1 stall after consume", {26'd0, stall}, 32'h00);

        // 2: collision, MEM read wins, then fetch
        rsp_q.push_back(32'hAAAA_0001);
        rsp_q.push_back(32'h2402_0005);
        push_txn(1'b0, 1'b0, 32'h2000, 32'h0, 4'hF);
        push_txn(1'b0, 1'b0, 32'h104, 32'h0, 4'hF);
        if_req = 1'b1;
        if_addr = 32'h104;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_addr = 32'h2000;
        mem_wdata = 32'h0;
        mem_sel = 4'hF;
        #1;
        chk("t2 stall c0", {26'd0, stall}, 32'h1F);
        step();
        chk("t2 stall data", {26'd0, stall}, 32'h1F);
        chk("t2 data addr", bus_addr, 32'h2000);
        step();
        chk("t2 mem_rdata", mem_rdata, 32'hAAAA_0001);
        chk("t2 stall after data", {26'd0, stall}, 32'h03);
        chk("t2 bus gap", {31'd0, bus_req}, 32'd0);
        step();
        chk("t2 fetch bus_req", {31'd0, bus_req}, 32'd1);
        chk("t2 fetch addr", bus_addr, 32'h104);
        chk("t2 stall fetch", {26'd0, stall}, 32'h03);
        step();
        chk("t2 if_inst", if_inst, 32'h2402_0005);
        chk("t2 stall done", {26'd0, stall}, 32'h00);
        step();

        // 3: write with three wait cycles
        ack_wait = 3;
        rsp_q.push_back(32'h0BAD_F00D);
        push_txn(1'b0, 1'b1, 32'h3000, 32'hDEAD_BEEF, 4'b0011);
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = 32'h3000;
        mem_wdata = 32'hDEAD_BEEF;
        mem_sel = 4'b0011;
        #1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus_req) cnt++;
            if (stall == 6'd0) break;
        end
        chk("t3 bus_req cycles", cnt, 32'd4);
        chk("t3 mem_rdata kept", mem_rdata, 32'hAAAA_0001);
        step();
        mem_we = 1'b0;

        // 4: timeout abort after WaitMax cycles
        ack_wait = -1;
        push_txn(1'b1, 1'b0, 32'h4000, 32'h0, 4'hF);
        mem_req = 1'b1;
        mem_addr = 32'h4000;
        mem_wdata = 32'h0;
        mem_sel = 4'hF;
        #1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4 bus_req held", {31'd0, bus_req}, 32'd1);
            chk("t4 stall held", {26'd0, stall}, 32'h1F);
            chk("t4 no early err", {31'd0, bus_err}, 32'd0);
        end
        step();
        chk("t4 bus_err pulse", {31'd0, bus_err}, 32'd1);
        chk("t4 bus_req dropped", {31'd0, bus_req}, 32'd0);
        chk("t4 mem_rdata zero", mem_rdata, 32'd0);
        chk("t4 stall released", {26'd0, stall}, 32'h00);
        step();
        chk("t4 bus_err one cycle", {31'd0, bus_err}, 32'd0);
        ack_wait = 0;

        // 5: stall priority
        rsp_q.push_back(32'h8C22_0004);
        push_txn(1'b0, 1'b0, 32'h200, 32'h0, 4'hF);
        if_req = 1'b1;
        if_addr = 32'h200;
        stallreq_ex = 1'b1;
        #1;
        chk("t5 ex over if", {26'd0, stall}, 32'h0F);
        step();
        step();
        chk("t5 if_inst", if_inst, 32'h8C22_0004);
        chk("t5 ex held", {26'd0, stall}, 32'h0F);
        stallreq_ex = 1'b0;
        stallreq_id = 1'b1;
        #1;
        chk("t5 id alone", {26'd0, stall}, 32'h07);
        stallreq_id = 1'b0;
        #1;
        chk("t5 none", {26'd0, stall}, 32'h00);
        step();
        // MEM outranks EX
        stallreq_ex = 1'b1;
        mem_req = 1'b1;
        #1;
        chk("t5 mem over ex", {26'd0, stall}, 32'h1F);
        mem_req = 1'b0;
        stallreq_ex = 1'b0;
        #1;

        // 6: async reset mid-DATA
        ack_wait = -1;
        mem_req = 1'b1;
        mem_addr = 32'h5000;
        #1;
        step();
        chk("t6 in DATA", {31'd0, bus_req}, 32'd1);
        step();
        rst = 1'b0;
        #1;
        chk("t6 bus_req async", {31'd0, bus_req}, 32'd0);
        chk("t6 stall async", {26'd0, stall}, 32'h00);
        mem_req = 1'b0;
        ack_wait = 0;
        step();
        rst = 1'b1;
        #1;
        chk("t6 idle after release", {31'd0, bus_req}, 32'd0);
        chk("t6 mem_rdata", mem_rdata, 32'd0);
        step();
        chk("t6 still idle", {31'd0, bus_req}, 32'd0);

        // Late ack while idle is ignored
        stray_ack = 1'b1;
        step();
        stray_ack = 1'b0;
        step();
        chk("stray ack if_inst", if_inst, 32'd0);
        chk("stray ack mem_rdata", mem_rdata, 32'd0);
        chk("stray ack bus_req", {31'd0, bus_req}, 32'd0);

        // Normal fetch after reset
        rsp_q.push_back(32'h1234_5678);
        push_txn(1'b0, 1'b0, 32'h300, 32'h0, 4'hF);
        if_req = 1'b1;
        if_addr = 32'h300;
        #1;
        step();
        step();
        chk("t6 fetch if_inst", if_inst, 32'h1234_5678);
        step();
        step();
        chk("scoreboard drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
